opl_wrqueue: RTL and testbench

- Single-clock, parametrised, show-ahead queue for OPL register writes.
- Each entry is an {address-tag, data} pair. The host-side write interface pushes entries; the sequencer CPU pops them through a status/data port pair.
- It generalises the fixed 10-bit/1024-entry write queue:
  - tag and data widths are configurable;
  - depth is configurable;
  - full-queue policy is selectable (reject newest or overwrite oldest);
  - it adds occupancy level, almost-full, sticky overflow and a saturating drop counter.

---
 rtl/opl_wrqueue.sv | 66 ++++++
 tb/tb_opl_wrqueue.sv | 123 ++++++++++++
 2 files changed

// File: rtl/opl_wrqueue.sv
// opl_wrqueue: show-ahead queue of {tag, data} OPL register writes with level, almost-full and overflow tracking
module opl_wrqueue #(
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_LEVEL  = 12,
  parameter int OVERWRITE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           din,
  input  logic                        rd,
  output logic [ADDR_W+DATA_W-1:0]    q,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  input  logic                        clr_ovf,
  output logic [7:0]                  drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int W  = ADDR_W + DATA_W;
  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wp, rp, nrp;
  logic            push, pop, lose, adv;
  logic [LW-1:0]   nlevel;
  always_comb begin
    pop    = rd && !empty;
    lose   = wr && full && !rd;
    push   = wr && (!full || rd || OVERWRITE != 0);
    adv    = pop || (lose && OVERWRITE != 0);
    nrp    = adv ? rp + 1'b1 : rp;
    nlevel = level + LW'(push) - LW'(adv);
  end
  always_ff @(posedge clk)
    if (!reset && push) mem[wp] <= {addr, din};
  // q is registered from the next head; bypass when the next head is the entry written this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wp          <= '0;
      rp          <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
      q           <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      rp          <= nrp;
      level       <= nlevel;
      empty       <= nlevel == '0;
      full        <= nlevel == LW'(DEPTH);
      almost_full <= nlevel >= LW'(AF_LEVEL);
      if (nlevel != '0) q <= (push && wp == nrp) ? {addr, din} : mem[nrp];
      overflow    <= lose || (overflow && !clr_ovf);
      drop_cnt    <= lose ? (clr_ovf ? 8'd1 : drop_cnt + {7'd0, drop_cnt != 8'hff}) :
                     clr_ovf ? 8'd0 : drop_cnt;
    end
  end
endmodule

// File: tb/tb_opl_wrqueue.sv
// tb_opl_wrqueue: randomized and directed check of both full-queue policies against a queue-based model
module tb_opl_wrqueue;
  logic       clk = 0, reset = 0, wr = 0, rd = 0, clr_ovf = 0;
  logic [1:0] addr = 0;
  logic [7:0] din = 0;
  logic [9:0] q0, q1;
  logic       e0, e1, f0, f1, af0, af1, ov0, ov1;
  logic [2:0] l0, l1;
  logic [7:0] d0, d1;
  int checks = 0, failures = 0;
  bit en = 0;
  logic [9:0] mq0[$], mq1[$];
  logic       mov0 = 0, mov1 = 0;
  logic [7:0] mdc0 = 0, mdc1 = 0;
  logic [9:0] meq0 = 0, meq1 = 0;

  always #5 clk = ~clk;

  opl_wrqueue #(.ADDR_W(2), .DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .OVERWRITE(0)) u0 (
    .clk(clk), .reset(reset), .wr(wr), .addr(addr), .din(din), .rd(rd), .q(q0), .empty(e0),
    .full(f0), .almost_full(af0), .level(l0), .overflow(ov0), .clr_ovf(clr_ovf), .drop_cnt(d0));
  opl_wrqueue #(.ADDR_W(2), .DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .OVERWRITE(1)) u1 (
    .clk(clk), .reset(reset), .wr(wr), .addr(addr), .din(din), .rd(rd), .q(q1), .empty(e1),
    .full(f1), .almost_full(af1), .level(l1), .overflow(ov1), .clr_ovf(clr_ovf), .drop_cnt(d1));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic upd(inout logic [9:0] qu[$], inout logic ov, inout logic [7:0] dc,
                     inout logic [9:0] eq, input bit ow);
    bit loss;
    logic [9:0] tmp;
    if (reset) begin
      qu.delete(); ov = 0; dc = 0; eq = 0;
    end else begin
      loss = wr && qu.size() == 4 && !rd;
      if (loss) begin
        if (ow) begin tmp = qu.pop_front(); qu.push_back({addr, din}); end
      end else begin
        if (rd && qu.size() > 0) tmp = qu.pop_front();
        if (wr) qu.push_back({addr, din});
      end
      if (loss) begin ov = 1; dc = clr_ovf ? 8'd1 : (dc == 8'd255 ? 8'd255 : dc + 8'd1); end
      else if (clr_ovf) begin ov = 0; dc = 0; end
      if (qu.size() > 0) eq = qu[0];
    end
  endtask

  always @(posedge clk) begin
    upd(mq0, mov0, mdc0, meq0, 0);
    upd(mq1, mov1, mdc1, meq1, 1);
    if (reset) en = 1;
  end

  always @(negedge clk) if (en) begin
    chk("q0", q0, meq0);         chk("q1", q1, meq1);
    chk("level0", l0, mq0.size()); chk("level1", l1, mq1.size());
    chk("empty0", e0, mq0.size() == 0); chk("empty1", e1, mq1.size() == 0);
    chk("full0", f0, mq0.size() == 4);  chk("full1", f1, mq1.size() == 4);
    chk("af0", af0, mq0.size() >= 3);   chk("af1", af1, mq1.size() >= 3);
    chk("ovf0", ov0, mov0); chk("ovf1", ov1, mov1);
    chk("drop0", d0, mdc0); chk("drop1", d1, mdc1);
  end

  task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d,
                      input logic r, input logic c, input logic rs);
    wr = w; addr = a; din = d; rd = r; clr_ovf = c; reset = rs;
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] exp0[4], exp1[4];
    exp0 = '{10'h111, 10'h222, 10'h333, 10'h044};
    exp1 = '{10'h222, 10'h333, 10'h044, 10'h255};
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_empty", e0, 1); chk("rst_level", l0, 0); chk("rst_q", q0, 0);
    step(1, 1, 8'h11, 0, 0, 0);
    chk("w1_level", l0, 1); chk("w1_q", q0, 10'h111); chk("w1_af", af0, 0);
    step(1, 2, 8'h22, 0, 0, 0); chk("w2_level", l0, 2); chk("w2_af", af0, 0);
    step(1, 3, 8'h33, 0, 0, 0); chk("w3_level", l0, 3); chk("w3_af", af0, 1); chk("w3_full", f0, 0);
    step(1, 0, 8'h44, 0, 0, 0); chk("w4_full", f0, 1); chk("w4_full_ow", f1, 1);
    step(1, 2, 8'h55, 0, 0, 0);
    chk("rej_drop", d0, 1); chk("rej_ovf", ov0, 1); chk("rej_q", q0, 10'h111);
    chk("ow_drop", d1, 1); chk("ow_level", l1, 4); chk("ow_q", q1, 10'h222);
    for (int i = 0; i < 4; i++) begin
      chk("pop_q0", q0, exp0[i]); chk("pop_q1", q1, exp1[i]);
      step(0, 0, 0, 1, 0, 0);
    end
    chk("drained0", e0, 1); chk("drained1", e1, 1);
    step(1, 1, 8'h01, 0, 0, 0);
    step(1, 2, 8'h02, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 2'($urandom), 8'($urandom), 1, 0, 0);
      chk("steady_level", l0, 2);
    end
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    chk("rd_empty_level", l0, 0);
    step(1, 3, 8'hab, 1, 0, 0);
    chk("wrrd_empty_level", l0, 1); chk("wrrd_empty_q", q0, 10'h3ab);
    for (int i = 0; i < 3; i++) step(1, 2'(i), 8'(8'h60 + i), 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 2'($urandom), 8'($urandom), 0, 0, 0);
    chk("sat_drop0", d0, 255); chk("sat_drop1", d1, 255);
    step(1, 1, 8'hcc, 0, 1, 0);
    chk("clr_loss_drop", d0, 1); chk("clr_loss_ovf", ov0, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("clr_drop", d0, 0); chk("clr_ovf", ov0, 0);
    step(1, 0, 8'h77, 1, 0, 1);
    chk("mid_rst_empty", e0, 1); chk("mid_rst_level", l0, 0); chk("mid_rst_level1", l1, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 55, 2'($urandom), 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 3, $urandom_range(0, 299) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
